// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencing controller: FSM states,
// operator codes, display-source codes and the decoded key class.
package calc_pkg;

  typedef enum logic [1:0] {
    S_OP1  = 2'd0,
    S_OP2  = 2'd1,
    S_CALC = 2'd2,
    S_RES  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    KEY_NONE  = 3'd0,
    KEY_CLEAR = 3'd1,
    KEY_EQ    = 3'd2,
    KEY_OP    = 3'd3,
    KEY_NUM   = 3'd4
  } key_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  localparam logic [1:0] DISP_OP1 = 2'b00;
  localparam logic [1:0] DISP_OP2 = 2'b01;
  localparam logic [1:0] DISP_RES = 2'b10;

  function automatic logic op_is_legal(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/calc_key_sel.sv
// Combinational priority decode of one filtered key strobe into a single
// key class, plus the legal-operator check.
module calc_key_sel
  import calc_pkg::*;
(
  input  logic       btn_valid,
  input  logic       is_num,
  input  logic       is_op,
  input  logic       is_eq,
  input  logic       clear,
  input  logic [1:0] op_val,
  output key_t       key,
  output logic       op_legal
);

  always_comb begin
    key = KEY_NONE;
    if (btn_valid) begin
      if (clear)       key = KEY_CLEAR;
      else if (is_eq)  key = KEY_EQ;
      else if (is_op)  key = KEY_OP;
      else if (is_num) key = KEY_NUM;
    end
  end

  assign op_legal = op_is_legal(op_val);

endmodule

// File: rtl/calc_seq_ctrl.sv
// Central sequencing FSM for the calculator datapath: operand entry,
// operator latch, timed ALU result capture, chaining and display select.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int ALU_WAIT   = 2,
  localparam int IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_valid,
  input  logic          is_num,
  input  logic          is_op,
  input  logic          is_eq,
  input  logic          clear,
  input  logic [3:0]    num_val,
  input  logic [1:0]    op_val,
  input  logic          alu_of,
  output logic          is_op1,
  output logic          is_op2,
  output logic          digit_we,
  output logic [IW-1:0] digit_idx,
  output logic [3:0]    digit_val,
  output logic [1:0]    op_latched,
  output logic          save,
  output logic          res_to_op1,
  output logic          mem_clear,
  output logic [1:0]    disp_sel,
  output logic          busy,
  output logic          err_key,
  output logic          of_lock
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;

  key_t key;
  logic op_legal;

  calc_key_sel u_key_sel (
    .btn_valid (btn_valid),
    .is_num    (is_num),
    .is_op     (is_op),
    .is_eq     (is_eq),
    .clear     (clear),
    .op_val    (op_val),
    .key       (key),
    .op_legal  (op_legal)
  );

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [1:0]    op_reg, op_next;
  logic          of_lock_reg, of_lock_next;
  logic          pend_reg, pend_next;
  logic [3:0]    pend_val_reg, pend_val_next;
  logic          digit_we_reg, digit_we_next;
  logic [IW-1:0] digit_idx_reg, digit_idx_next;
  logic [3:0]    digit_val_reg, digit_val_next;
  logic          save_reg, save_next;
  logic          res_reg, res_next;
  logic          mem_clear_reg, mem_clear_next;
  logic          err_reg, err_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_OP1;
      cnt_reg       <= '0;
      timer_reg     <= '0;
      op_reg        <= OP_ADD;
      of_lock_reg   <= 1'b0;
      pend_reg      <= 1'b0;
      pend_val_reg  <= '0;
      digit_we_reg  <= 1'b0;
      digit_idx_reg <= '0;
      digit_val_reg <= '0;
      save_reg      <= 1'b0;
      res_reg       <= 1'b0;
      mem_clear_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      timer_reg     <= timer_next;
      op_reg        <= op_next;
      of_lock_reg   <= of_lock_next;
      pend_reg      <= pend_next;
      pend_val_reg  <= pend_val_next;
      digit_we_reg  <= digit_we_next;
      digit_idx_reg <= digit_idx_next;
      digit_val_reg <= digit_val_next;
      save_reg      <= save_next;
      res_reg       <= res_next;
      mem_clear_reg <= mem_clear_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    timer_next     = timer_reg;
    op_next        = op_reg;
    of_lock_next   = of_lock_reg;
    pend_next      = 1'b0;
    pend_val_next  = pend_val_reg;
    digit_we_next  = 1'b0;
    digit_idx_next = digit_idx_reg;
    digit_val_next = digit_val_reg;
    save_next      = 1'b0;
    res_next       = 1'b0;
    mem_clear_next = 1'b0;
    err_next       = 1'b0;

    // First digit of a fresh calculation lands one cycle after the memory wipe.
    if (pend_reg) begin
      digit_we_next  = 1'b1;
      digit_idx_next = '0;
      digit_val_next = pend_val_reg;
      cnt_next       = CW'(1);
    end

    if (key == KEY_CLEAR) begin
      mem_clear_next = 1'b1;
      digit_we_next  = 1'b0;
      state_next     = S_OP1;
      cnt_next       = '0;
      timer_next     = '0;
      op_next        = OP_ADD;
      of_lock_next   = 1'b0;
    end else begin
      unique case (state_reg)
        S_OP1, S_OP2: begin
          if (key == KEY_NUM) begin
            if (cnt_reg < CW'(MAX_DIGITS)) begin
              digit_we_next  = 1'b1;
              digit_idx_next = cnt_reg[IW-1:0];
              digit_val_next = num_val;
              cnt_next       = cnt_reg + CW'(1);
            end else begin
              err_next = 1'b1;
            end
          end else if (key == KEY_OP) begin
            if (state_reg == S_OP1 && op_legal) begin
              op_next    = op_val;
              state_next = S_OP2;
              cnt_next   = '0;
            end else begin
              err_next = 1'b1;
            end
          end else if (key == KEY_EQ) begin
            if (state_reg == S_OP2) begin
              state_next = S_CALC;
              timer_next = TW'(ALU_WAIT - 1);
            end else begin
              err_next = 1'b1;
            end
          end
        end
        S_CALC: begin
          if (key != KEY_NONE) err_next = 1'b1;
          if (timer_reg == '0) begin
            save_next    = 1'b1;
            of_lock_next = alu_of;
            state_next   = S_RES;
          end else begin
            timer_next = timer_reg - TW'(1);
          end
        end
        S_RES: begin
          if (key == KEY_NUM) begin
            mem_clear_next = 1'b1;
            pend_next      = 1'b1;
            pend_val_next  = num_val;
            state_next     = S_OP1;
            cnt_next       = '0;
            of_lock_next   = 1'b0;
          end else if (key == KEY_OP) begin
            if (op_legal && !of_lock_reg) begin
              res_next   = 1'b1;
              op_next    = op_val;
              state_next = S_OP2;
              cnt_next   = '0;
            end else begin
              err_next = 1'b1;
            end
          end else if (key == KEY_EQ) begin
            err_next = 1'b1;
          end
        end
        default: state_next = S_OP1;
      endcase
    end
  end

  // The result is not valid until save, so S_CALC keeps showing operand 2.
  always_comb begin
    disp_sel = DISP_OP1;
    unique case (state_reg)
      S_OP1:   disp_sel = DISP_OP1;
      S_OP2:   disp_sel = DISP_OP2;
      S_CALC:  disp_sel = DISP_OP2;
      S_RES:   disp_sel = DISP_RES;
      default: disp_sel = DISP_OP1;
    endcase
  end

  assign is_op1     = (state_reg == S_OP1);
  assign is_op2     = (state_reg == S_OP2);
  assign busy       = (state_reg == S_CALC);
  assign digit_we   = digit_we_reg;
  assign digit_idx  = digit_idx_reg;
  assign digit_val  = digit_val_reg;
  assign op_latched = op_reg;
  assign save       = save_reg;
  assign res_to_op1 = res_reg;
  assign mem_clear  = mem_clear_reg;
  assign err_key    = err_reg;
  assign of_lock    = of_lock_reg;

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Central sequencing FSM for the calculator datapath.
- Consumes the filtered, one-strobe-per-keypress decoder outputs.
- Drives operand-entry enables, digit writes, operator latch, ALU result capture (save) and display selection for fsm_memory, alu_core, mux_and_bcd_converter and controlador_rgb_buzzer.
- Sits between d_ff_decoder and the datapath; replaces the loose is_op1/is_op2/save top-level inputs.

Parameters:
- MAX_DIGITS, 4, maximum BCD digits per operand.
- ALU_WAIT, 2, cycles between the equals key and the save pulse (ALU + BCD settle).

Ports:
- clk  in  1  system clock (12 MHz).
- reset  in  1  synchronous, active-high reset.
- btn_valid  in  1  one-cycle strobe; a filtered key is present.
- is_num  in  1  key is a digit.
- is_op  in  1  key is an operator.
- is_eq  in  1  key is equals.
- clear  in  1  key is clear.
- num_val  in  4  digit value, 0-9.
- op_val  in  2  operator: 00 add, 01 sub, 10/11 reserved.
- alu_of  in  1  ALU overflow flag, sampled on the save cycle.
- is_op1  out  1  operand-1 entry active (level).
- is_op2  out  1  operand-2 entry active (level).
- digit_we  out  1  one-cycle digit write strobe to memory.
- digit_idx  out  2  digit position being written, 0 = first digit.
- digit_val  out  4  registered num_val for the write.
- op_latched  out  2  operator held for the ALU.
- save  out  1  one-cycle pulse; capture the result.
- res_to_op1  out  1  one-cycle pulse; copy the result into operand-1 (chaining).
- mem_clear  out  1  one-cycle pulse; zero all operand and result storage.
- disp_sel  out  2  display source: 00 op1, 01 op2, 10 result.
- busy  out  1  high in S_CALC.
- err_key  out  1  one-cycle pulse; key rejected.
- of_lock  out  1  held overflow flag of the current result.

Behaviour:
- All outputs are registered. A key accepted at cycle t produces its effects at t+1.
- Reset values:
  - state S_OP1; is_op1 = 1; all other outputs 0.
  - digit counter cnt = 0; timer = 0; disp_sel = 00.
- Key decode priority, when several flags are high with btn_valid: clear > is_eq > is_op > is_num.
- btn_valid low means no action, regardless of the flags.
- clear (any state, including S_CALC): mem_clear pulse; go to S_OP1; cnt = 0; op_latched = 00; of_lock = 0.
- S_OP1 (is_op1 = 1, disp_sel = 00):
  - num with cnt < MAX_DIGITS: digit_we pulse with digit_idx = cnt and digit_val = num_val; then cnt++.
  - num with cnt == MAX_DIGITS: err_key; no write.
  - op with op_val ≤ 01: latch op_latched; go to S_OP2; cnt = 0. cnt == 0 is legal (operand = 0).
  - op with reserved op_val: err_key.
  - eq: err_key.
- S_OP2 (is_op2 = 1, disp_sel = 01):
  - num: same rules as S_OP1.
  - op: err_key; the operator is not changed.
  - eq: go to S_CALC; timer = ALU_WAIT - 1.
- S_CALC (busy = 1, is_op1 = is_op2 = 0):
  - Any key except clear gives err_key.
  - timer decrements each cycle. On the cycle timer == 0: save pulse; of_lock <= alu_of; go to S_RES.
  - Eq-accept to save pulse latency = ALU_WAIT + 1 cycles.
- S_RES (disp_sel = 10):
  - num: mem_clear pulse at t+1; digit_we with idx 0 at t+2; cnt = 1; state S_OP1. No key can be accepted at t+1, because the filter guarantees spaced strobes.
  - op (legal) with of_lock = 0: res_to_op1 pulse; latch op; go to S_OP2; cnt = 0.
  - op with of_lock = 1: err_key; stay in S_RES.
  - eq: err_key.
- cnt saturates at MAX_DIGITS and never wraps. digit_idx width must hold MAX_DIGITS - 1.
- Reset asserted mid-operation (including S_CALC) overrides everything on that edge. No save is emitted.
- Pulses (digit_we, save, res_to_op1, mem_clear, err_key) never last more than one cycle.
- save and digit_we are never high in the same cycle.

Decomposition:
- calc_pkg holds:
  - state encoding S_OP1 = 0, S_OP2 = 1, S_CALC = 2, S_RES = 3.
  - operator codes OP_ADD = 00, OP_SUB = 01.
  - disp_sel codes DISP_OP1/DISP_OP2/DISP_RES.
- One natural sub-module: calc_key_sel. It is the combinational priority decode of the key class (clear/eq/op/num/none) plus the legal-operator check. The FSM, counters and pulse registers stay in calc_seq_ctrl.

Test Plan:
- Reset, then keys 1,2,3 → digit_we ×3 with idx 0,1,2 and values 1,2,3; is_op1 = 1; cnt = 3.
- Five digits in S_OP1 → four writes; the fifth gives an err_key pulse and no digit_we.
- Sequence 12, +, 5, = → op_latched = 00; state changes S_OP2 → S_CALC; save pulse exactly 3 cycles after the eq strobe; disp_sel = 10.
- In S_RES with alu_of = 0 at save, press − → res_to_op1 pulse, op_latched = 01, is_op2 = 1. Repeat with alu_of = 1 → err_key; stays in S_RES.
- clear strobe in S_CALC → mem_clear pulse; no save ever emitted; state S_OP1.
- Simultaneous is_num + clear with btn_valid → clear wins: mem_clear pulse, no digit_we. Reset asserted while in S_OP2 → all outputs return to reset values next cycle.
